// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that sequences one shared I2C master among NUM_REQ clients.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog and master-reset recovery.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int BUSY_WAIT      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_400,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ-1:0]     req_burst,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_err,
    output logic [15:0]            rsp_rdata,
    output logic                   m_rw,
    output logic                   m_start_txn,
    output logic                   m_next_byte,
    output logic [6:0]             m_sub_addr,
    output logic [7:0]             m_data_in,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_ack_error,
    input  logic                   m_data_ready,
    input  logic [7:0]             m_data_out,
    output logic                   m_rst_n
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND
`ifdef I2C_ARB_TIMEOUT_EN
        , S_RECOVER
`endif
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_gnt_idx;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_err;
    logic               r_err;
    logic               r_done_prev;
    logic [15:0]        r_rdata;
    logic [15:0]        r_busy_cnt;
    logic [1:0]         r_byte_cnt;
    logic               r_m_rw;
    logic               r_m_start_txn;
    logic               r_m_next_byte;
    logic [6:0]         r_m_sub_addr;
    logic [7:0]         r_m_data_in;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0]        r_wdog;
    logic [1:0]         r_rec_cnt;
    logic               r_m_rst_n;
`endif

    logic [6:0] w_addr  [NUM_REQ];
    logic [7:0] w_wdata [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_addr[gi]  = req_addr[7*gi +: 7];
            assign w_wdata[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    // Scan from the highest offset down so the nearest set bit at/after r_rr_ptr wins.
    logic [IW-1:0] w_win_idx;
    always_comb begin
        int            c_idx;
        logic [IW-1:0] cand;
        w_win_idx = '0;
        c_idx     = 0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c_idx = int'(r_rr_ptr) + k;
            if (c_idx >= NUM_REQ) c_idx = c_idx - NUM_REQ;
            cand = IW'(c_idx);
            if (req[cand]) w_win_idx = cand;
        end
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_gnt_idx     <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_err     <= 1'b0;
            r_err         <= 1'b0;
            r_done_prev   <= 1'b0;
            r_rdata       <= '0;
            r_busy_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_m_rw        <= 1'b0;
            r_m_start_txn <= 1'b0;
            r_m_next_byte <= 1'b0;
            r_m_sub_addr  <= '0;
            r_m_data_in   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_rec_cnt     <= '0;
            r_m_rst_n     <= 1'b1;
`endif
        end else begin
            r_done_prev <= m_done;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt     <= NUM_REQ'(1) << w_win_idx;
                        r_gnt_idx <= w_win_idx;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_m_rw        <= req_rw[r_gnt_idx];
                    r_m_next_byte <= req_burst[r_gnt_idx];
                    r_m_sub_addr  <= w_addr[r_gnt_idx];
                    r_m_data_in   <= w_wdata[r_gnt_idx];
                    r_rdata       <= '0;
                    r_byte_cnt    <= '0;
                    r_err         <= 1'b0;
                    r_m_start_txn <= 1'b1;
                    r_state       <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    r_m_start_txn <= 1'b0;
                    r_busy_cnt    <= '0;
                    r_state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (m_busy) begin
`ifdef I2C_ARB_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                        r_state <= S_WAIT_DONE;
                    end else if (r_busy_cnt == 16'(BUSY_WAIT - 1)) begin
                        r_err       <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_RESPOND;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    // Only the first two bytes are kept; write transactions never touch rdata.
                    if (m_data_ready && (r_byte_cnt < 2'd2)) begin
                        if (r_m_rw) begin
                            if (r_byte_cnt == 2'd0) r_rdata[15:8] <= m_data_out;
                            else                    r_rdata[7:0]  <= m_data_out;
                        end
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    if (m_ack_error) r_err <= 1'b1;
                    if (m_done && !r_done_prev) begin
                        r_rsp_valid <= r_gnt;
                        r_rsp_err   <= r_err | m_ack_error;
                        r_state     <= S_RESPOND;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
                        r_m_rst_n <= 1'b0;
                        r_rec_cnt <= '0;
                        r_state   <= S_RECOVER;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                S_RESPOND: begin
                    r_rsp_valid <= '0;
                    r_rsp_err   <= 1'b0;
                    r_gnt       <= '0;
                    r_rr_ptr    <= (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                    r_state     <= S_IDLE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                S_RECOVER: begin
                    if (r_rec_cnt == 2'd3) begin
                        r_m_rst_n   <= 1'b1;
                        r_err       <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_RESPOND;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + 2'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rdata;
    assign m_rw        = r_m_rw;
    assign m_start_txn = r_m_start_txn;
    assign m_next_byte = r_m_next_byte;
    assign m_sub_addr  = r_m_sub_addr;
    assign m_data_in   = r_m_data_in;
`ifdef I2C_ARB_TIMEOUT_EN
    assign m_rst_n     = r_m_rst_n;
`else
    assign m_rst_n     = 1'b1;
`endif
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: a simple I2C-master model answers each launch and
// a round-robin reference model predicts grants, response data and error status.
module tb_i2c_bus_arbiter;
    localparam int N  = 4;
    localparam int BW = 8;
    localparam int TO = 64;

    logic           clk_400 = 1'b0;
    logic           rst_n   = 1'b1;
    logic [N-1:0]   req, req_rw, req_burst;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt, rsp_valid;
    logic           rsp_err;
    logic [15:0]    rsp_rdata;
    logic           m_rw, m_start_txn, m_next_byte;
    logic [6:0]     m_sub_addr;
    logic [7:0]     m_data_in;
    logic           m_busy, m_done, m_ack_error, m_data_ready;
    logic [7:0]     m_data_out;
    logic           m_rst_n;

    always #5 clk_400 = ~clk_400;

    i2c_bus_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_400(clk_400), .rst_n(rst_n),
        .req(req), .req_rw(req_rw), .req_burst(req_burst),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .m_rw(m_rw), .m_start_txn(m_start_txn), .m_next_byte(m_next_byte),
        .m_sub_addr(m_sub_addr), .m_data_in(m_data_in),
        .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error),
        .m_data_ready(m_data_ready), .m_data_out(m_data_out),
        .m_rst_n(m_rst_n)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state: round-robin pointer and each client's transaction fields.
    int         model_ptr = 0;
    logic       c_rw   [N];
    logic       c_burst[N];
    logic [6:0] c_addr [N];
    logic [7:0] c_wd   [N];

    typedef struct packed {
        logic         to;
        logic [N-1:0] gnt;
        logic [6:0]   addr;
        logic [7:0]   wd;
        logic         rw;
        logic         nxt;
        int           lat;
        int           starts;
        logic         early;
        logic [N-1:0] rv;
        logic         err;
        logic [15:0]  rd;
        logic [N-1:0] rgnt;
    } obs_t;

    function automatic int pick(input int ptr, input logic [N-1:0] vec);
        for (int k = 0; k < N; k++)
            if (vec[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] exp_rdata(input logic rw, input int nb,
                                              input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] r;
        r = 16'h0000;
        if (rw && nb > 0) r[15:8] = b0;
        if (rw && nb > 1) r[7:0]  = b1;
        return r;
    endfunction

    task automatic set_client(input int c, input logic rw, input logic burst,
                              input logic [6:0] a, input logic [7:0] d);
        c_rw[c] = rw; c_burst[c] = burst; c_addr[c] = a; c_wd[c] = d;
        req_rw[c] = rw; req_burst[c] = burst;
        req_addr[7*c +: 7]  = a;
        req_wdata[8*c +: 8] = d;
    endtask

    task automatic rand_client(input int c);
        set_client(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   7'($urandom_range(1, 127)), 8'($urandom_range(0, 255)));
    endtask

    // Master model: waits for the launch, goes busy, emits nb data bytes, optional NACK, then done.
    // Returns at the falling edge where the response pulse is expected.
    task automatic serve_one(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input bit nack, output obs_t o);
        logic [7:0] bytes [3];
        int n;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        o = '0;
        n = 0;
        while (m_start_txn !== 1'b1 && n < 40) begin
            @(negedge clk_400);
            n++;
        end
        o.lat = n;
        if (m_start_txn !== 1'b1) begin
            o.to = 1'b1;
            return;
        end
        o.gnt = gnt; o.addr = m_sub_addr; o.wd = m_data_in; o.rw = m_rw; o.nxt = m_next_byte;
        @(negedge clk_400);
        if (m_start_txn) o.starts++;
        m_busy = 1'b1;
        repeat (2) begin
            @(negedge clk_400);
            if (m_start_txn) o.starts++;
            if (|rsp_valid) o.early = 1'b1;
        end
        for (int i = 0; i < nb; i++) begin
            m_data_out = bytes[i]; m_data_ready = 1'b1;
            @(negedge clk_400);
            m_data_ready = 1'b0; m_data_out = 8'h00;
            @(negedge clk_400);
            if (m_start_txn) o.starts++;
            if (|rsp_valid) o.early = 1'b1;
        end
        if (nack) begin
            m_ack_error = 1'b1;
            @(negedge clk_400);
            m_ack_error = 1'b0;
        end
        m_busy = 1'b0; m_done = 1'b1;
        @(negedge clk_400);
        o.rv = rsp_valid; o.err = rsp_err; o.rd = rsp_rdata; o.rgnt = gnt;
        m_done = 1'b0;
        $display("txn gnt=%b addr=%h wdata=%h rw=%b rsp_valid=%b rsp_err=%b rdata=%h",
                 o.gnt, o.addr, o.wd, o.rw, o.rv, o.err, o.rd);
    endtask

    task automatic test_reset;
        req = '0; req_rw = '0; req_burst = '0; req_addr = '0; req_wdata = '0;
        m_busy = 0; m_done = 0; m_ack_error = 0; m_data_ready = 0; m_data_out = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, rsp_rdata} !== '0)
            $display("FAIL reset_rsp: gnt=%b rsp_valid=%b rsp_err=%b rdata=%h want all 0",
                     gnt, rsp_valid, rsp_err, rsp_rdata);
        else passed++;
        checks++;
        if ({m_start_txn, m_rw, m_next_byte, m_sub_addr, m_data_in} !== '0)
            $display("FAIL reset_master: start=%b rw=%b next=%b addr=%h data=%h want all 0",
                     m_start_txn, m_rw, m_next_byte, m_sub_addr, m_data_in);
        else passed++;
        checks++;
        if (m_rst_n !== 1'b1) $display("FAIL reset_m_rst_n: got %b want 1", m_rst_n);
        else passed++;
        repeat (3) @(negedge clk_400);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single_write;
        obs_t o;
        @(negedge clk_400);
        set_client(0, 1'b0, 1'b0, 7'h50, 8'hA5);
        req[0] = 1'b1;
        @(negedge clk_400);
        checks++;
        if (gnt !== 4'b0001 || m_start_txn !== 1'b0)
            $display("FAIL write_gnt_cycle1: gnt=%b start=%b want 0001/0", gnt, m_start_txn);
        else passed++;
        serve_one(0, 8'h00, 8'h00, 8'h00, 1'b0, o);
        checks++;
        if (o.lat !== 1) $display("FAIL write_start_latency: got %0d want 1", o.lat);
        else passed++;
        checks++;
        if ({o.addr, o.wd, o.rw, o.starts} !== {7'h50, 8'hA5, 1'b0, 32'd0})
            $display("FAIL write_launch: addr=%h data=%h rw=%b extra_starts=%0d want 50/a5/0/0",
                     o.addr, o.wd, o.rw, o.starts);
        else passed++;
        checks++;
        if ({o.early, o.rv, o.err, o.rd, o.rgnt} !== {1'b0, 4'b0001, 1'b0, 16'h0, 4'b0001})
            $display("FAIL write_rsp: early=%b rsp_valid=%b err=%b rdata=%h gnt=%b want 0/0001/0/0000/0001",
                     o.early, o.rv, o.err, o.rd, o.rgnt);
        else passed++;
        req[0] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0001) + 1) % N;
        @(negedge clk_400);
        checks++;
        if (rsp_valid !== 4'b0000 || gnt !== 4'b0000)
            $display("FAIL write_pulse_width: rsp_valid=%b gnt=%b want 0000/0000", rsp_valid, gnt);
        else passed++;
    endtask

    task automatic test_burst_read;
        obs_t o;
        @(negedge clk_400);
        set_client(2, 1'b1, 1'b1, 7'h3C, 8'h00);
        req[2] = 1'b1;
        serve_one(2, 8'h12, 8'h34, 8'h00, 1'b0, o);
        checks++;
        if ({o.lat, o.gnt, o.rw, o.nxt, o.addr} !== {32'd2, 4'b0100, 1'b1, 1'b1, 7'h3C})
            $display("FAIL burst_launch: lat=%0d gnt=%b rw=%b next=%b addr=%h want 2/0100/1/1/3c",
                     o.lat, o.gnt, o.rw, o.nxt, o.addr);
        else passed++;
        checks++;
        if ({o.rv, o.err, o.rd} !== {4'b0100, 1'b0, 16'h1234})
            $display("FAIL burst_rsp: rsp_valid=%b err=%b rdata=%h want 0100/0/1234", o.rv, o.err, o.rd);
        else passed++;
        req[2] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0100) + 1) % N;
    endtask

    task automatic test_ack_error;
        obs_t o;
        @(negedge clk_400);
        set_client(3, 1'b1, 1'b0, 7'h77, 8'h00);
        req[3] = 1'b1;
        serve_one(0, 8'h00, 8'h00, 8'h00, 1'b1, o);
        checks++;
        if ({o.lat, o.rv, o.err, o.rd} !== {32'd2, 4'b1000, 1'b1, 16'h0})
            $display("FAIL nack_rsp: lat=%0d rsp_valid=%b err=%b rdata=%h want 2/1000/1/0000",
                     o.lat, o.rv, o.err, o.rd);
        else passed++;
        req[3] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b1000) + 1) % N;
        @(negedge clk_400);
        set_client(1, 1'b0, 1'b0, 7'h21, 8'h5E);
        req[1] = 1'b1;
        serve_one(0, 8'h00, 8'h00, 8'h00, 1'b0, o);
        checks++;
        if ({o.gnt, o.addr, o.wd, o.rv, o.err} !== {4'b0010, 7'h21, 8'h5E, 4'b0010, 1'b0})
            $display("FAIL after_nack: gnt=%b addr=%h data=%h rsp_valid=%b err=%b want 0010/21/5e/0010/0",
                     o.gnt, o.addr, o.wd, o.rv, o.err);
        else passed++;
        req[1] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0010) + 1) % N;
    endtask

    task automatic test_launch_fail;
        logic st, early;
        @(negedge clk_400);
        set_client(0, 1'b0, 1'b0, 7'h11, 8'h22);
        req[0] = 1'b1;
        st = 1'b0; early = 1'b0;
        for (int k = 1; k <= BW + 3; k++) begin
            @(negedge clk_400);
            if (k == 2) st = m_start_txn;
            if (k < BW + 3 && rsp_valid !== 4'b0000) early = 1'b1;
        end
        checks++;
        if (st !== 1'b1 || early !== 1'b0)
            $display("FAIL launch_fail_timing: start_at_2=%b early_rsp=%b want 1/0", st, early);
        else passed++;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b1, 16'h0})
            $display("FAIL launch_fail_rsp: rsp_valid=%b err=%b rdata=%h want 0001/1/0000",
                     rsp_valid, rsp_err, rsp_rdata);
        else passed++;
        req[0] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0001) + 1) % N;
    endtask

    task automatic test_timeout;
        int n;
        @(negedge clk_400);
        set_client(2, 1'b1, 1'b0, 7'h42, 8'h00);
        req[2] = 1'b1;
        n = 0;
        while (m_start_txn !== 1'b1 && n < 40) begin
            @(negedge clk_400);
            n++;
        end
        checks++;
        if (n !== 2) $display("FAIL timeout_launch: start latency %0d want 2", n);
        else passed++;
        @(negedge clk_400);
        m_busy = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        while (m_rst_n !== 1'b0 && n < 200) begin
            @(negedge clk_400);
            n++;
        end
        checks++;
        if (m_rst_n !== 1'b0) $display("FAIL timeout_recover: m_rst_n=%b after %0d cycles want 0", m_rst_n, n);
        else passed++;
        m_busy = 1'b0;
        n = 0;
        while (m_rst_n === 1'b0 && n < 20) begin
            @(negedge clk_400);
            n++;
        end
        checks++;
        if (n !== 4) $display("FAIL timeout_rst_len: m_rst_n low %0d cycles want 4", n);
        else passed++;
        checks++;
        if ({rsp_valid, rsp_err} !== {4'b0100, 1'b1})
            $display("FAIL timeout_rsp: rsp_valid=%b err=%b want 0100/1", rsp_valid, rsp_err);
        else passed++;
        req[2] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0100) + 1) % N;
`else
        n = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk_400);
            if (rsp_valid !== 4'b0000 || m_rst_n !== 1'b1) n++;
        end
        checks++;
        if (n !== 0 || gnt !== 4'b0100)
            $display("FAIL wait_forever: bad_cycles=%0d gnt=%b want 0/0100", n, gnt);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        m_busy = 1'b0;
        req[2] = 1'b0;
        @(negedge clk_400);
        rst_n = 1'b1;
        model_ptr = 0;
`endif
    endtask

    task automatic test_round_robin;
        obs_t o;
        int w;
        logic [7:0] b0, b1;
        int nb;
        @(negedge clk_400);
        rst_n = 1'b0;
        for (int c = 0; c < N; c++) rand_client(c);
        req = 4'b1111;
        @(negedge clk_400);
        rst_n = 1'b1;
        model_ptr = 0;
        for (int t = 0; t < 5; t++) begin
            b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
            nb = $urandom_range(0, 3);
            serve_one(nb, b0, b1, 8'hEE, 1'b0, o);
            w = pick(model_ptr, 4'b1111);
            checks++;
            if ({o.lat, o.gnt, o.starts} !== {((t == 0) ? 32'd2 : 32'd3), 4'(1 << w), 32'd0})
                $display("FAIL rr_grant%0d: lat=%0d gnt=%b extra_starts=%0d want %0d/%b/0",
                         t, o.lat, o.gnt, o.starts, (t == 0) ? 2 : 3, 4'(1 << w));
            else passed++;
            checks++;
            if ({o.addr, o.wd, o.rw, o.rv, o.err, o.rd} !==
                {c_addr[w], c_wd[w], c_rw[w], 4'(1 << w), 1'b0, exp_rdata(c_rw[w], nb, b0, b1)})
                $display("FAIL rr_txn%0d: addr=%h data=%h rw=%b rsp_valid=%b err=%b rdata=%h want %h/%h/%b/%b/0/%h",
                         t, o.addr, o.wd, o.rw, o.rv, o.err, o.rd, c_addr[w], c_wd[w], c_rw[w],
                         4'(1 << w), exp_rdata(c_rw[w], nb, b0, b1));
            else passed++;
            model_ptr = (w + 1) % N;
        end
        req = '0;
    endtask

    task automatic test_random;
        obs_t o;
        logic [N-1:0] vec;
        int w, nb, first;
        bit nack;
        logic [7:0] b0, b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk_400);
            vec = 4'($urandom_range(1, 15));
            for (int c = 0; c < N; c++) if (vec[c]) rand_client(c);
            req = vec;
            first = 1;
            while (vec != '0) begin
                b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
                nb = $urandom_range(0, 3);
                nack = ($urandom_range(0, 3) == 0);
                serve_one(nb, b0, b1, 8'hC3, nack, o);
                w = pick(model_ptr, vec);
                checks++;
                if ({o.lat, o.gnt, o.addr, o.wd, o.rw} !==
                    {(first != 0) ? 32'd2 : 32'd3, 4'(1 << w), c_addr[w], c_wd[w], c_rw[w]})
                    $display("FAIL rand_launch: lat=%0d gnt=%b addr=%h data=%h rw=%b want client %0d %h/%h/%b",
                             o.lat, o.gnt, o.addr, o.wd, o.rw, w, c_addr[w], c_wd[w], c_rw[w]);
                else passed++;
                checks++;
                if ({o.rv, o.err, o.rd} !== {4'(1 << w), nack, exp_rdata(c_rw[w], nb, b0, b1)})
                    $display("FAIL rand_rsp: rsp_valid=%b err=%b rdata=%h want %b/%b/%h",
                             o.rv, o.err, o.rd, 4'(1 << w), nack, exp_rdata(c_rw[w], nb, b0, b1));
                else passed++;
                req[w] = 1'b0;
                vec[w] = 1'b0;
                model_ptr = (w + 1) % N;
                first = 0;
            end
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int n;
        @(negedge clk_400);
        set_client(1, 1'b0, 1'b0, 7'h0F, 8'h0F);
        req[1] = 1'b1;
        serve_one(0, 8'h00, 8'h00, 8'h00, 1'b0, o);
        req[1] = 1'b0;
        model_ptr = (pick(model_ptr, 4'b0010) + 1) % N;
        @(negedge clk_400);
        set_client(2, 1'b1, 1'b1, 7'h2A, 8'h5C);
        req[2] = 1'b1;
        n = 0;
        while (m_start_txn !== 1'b1 && n < 40) begin
            @(negedge clk_400);
            n++;
        end
        @(negedge clk_400);
        m_busy = 1'b1;
        m_data_out = 8'h99; m_data_ready = 1'b1;
        @(negedge clk_400);
        m_data_ready = 1'b0;
        @(negedge clk_400);
        checks++;
        if (gnt !== 4'b0100 || m_sub_addr !== 7'h2A)
            $display("FAIL mid_precond: gnt=%b addr=%h want 0100/2a", gnt, m_sub_addr);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, rsp_rdata, m_start_txn, m_rw, m_next_byte, m_sub_addr, m_data_in, m_rst_n}
            !== {4'b0, 4'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 7'h0, 8'h0, 1'b1})
            $display("FAIL mid_reset: gnt=%b rv=%b err=%b rd=%h start=%b rw=%b nxt=%b addr=%h data=%h m_rst_n=%b want reset values",
                     gnt, rsp_valid, rsp_err, rsp_rdata, m_start_txn, m_rw, m_next_byte,
                     m_sub_addr, m_data_in, m_rst_n);
        else passed++;
        m_busy = 1'b0; m_data_out = 8'h00; req = '0;
        @(negedge clk_400);
        rst_n = 1'b1;
        model_ptr = 0;
        set_client(0, 1'b0, 1'b0, 7'h05, 8'h66);
        set_client(3, 1'b1, 1'b0, 7'h6B, 8'h00);
        req = 4'b1001;
        serve_one(0, 8'h00, 8'h00, 8'h00, 1'b0, o);
        n = pick(model_ptr, 4'b1001);
        checks++;
        if ({o.lat, o.gnt, o.addr, o.rv} !== {32'd2, 4'(1 << n), c_addr[n], 4'(1 << n)})
            $display("FAIL post_reset_grant: lat=%0d gnt=%b addr=%h rsp_valid=%b want 2/%b/%h/%b",
                     o.lat, o.gnt, o.addr, o.rv, 4'(1 << n), c_addr[n], 4'(1 << n));
        else passed++;
        req[n] = 1'b0;
        model_ptr = (n + 1) % N;
        serve_one(1, 8'hAB, 8'h00, 8'h00, 1'b0, o);
        n = pick(model_ptr, 4'b1000);
        checks++;
        if ({o.lat, o.gnt, o.rv, o.err, o.rd} !== {32'd3, 4'(1 << n), 4'(1 << n), 1'b0, 16'hAB00})
            $display("FAIL post_reset_next: lat=%0d gnt=%b rsp_valid=%b err=%b rdata=%h want 3/%b/%b/0/ab00",
                     o.lat, o.gnt, o.rv, o.err, o.rd, 4'(1 << n), 4'(1 << n));
        else passed++;
        req[n] = 1'b0;
        model_ptr = (n + 1) % N;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_burst_read;
        test_ack_error;
        test_launch_fail;
        test_timeout;
        test_round_robin;
        test_random;
        test_reset_mid;
        repeat (2) @(negedge clk_400);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: bench did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "time limit");
    end
endmodule
